// File: rtl/id_dispatch_ctrl.sv
// Dual-slot in-order dispatch controller between instruction buffer and decode.
// Latency: ib_accept_o is combinational; accepted slots appear on dispatch_* one cycle later.
// Backpressure: when decode holds a valid bundle (dispatch_ready_i=0), outputs hold and nothing is accepted.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   ib_valid_i/pc/instr      per-slot instruction buffer head (slot 0 oldest)
//   ib_is_mem/branch/priv_i  per-slot pre-decode class bits
//   ib_accept_o              prefix accept mask back to the instruction buffer
//   dispatch_valid/pc/instr  registered bundle to decode, consumed on dispatch_ready_i
//   backend_empty_i          nothing in flight past decode (releases PRIV_DRAIN)
//   flush_i                  backend flush, highest priority
//   state_o                  0 RUN, 1 PRIV_DRAIN, 2 FLUSH
//   perf_dispatch_cnt_o      wrapping count of instructions consumed by decode
module id_dispatch_ctrl #(
  parameter int ID_WIDTH  = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ID_WIDTH-1:0]           ib_valid_i,
  input  logic [ID_WIDTH-1:0][31:0]     ib_pc_i,
  input  logic [ID_WIDTH-1:0][31:0]     ib_instr_i,
  input  logic [ID_WIDTH-1:0]           ib_is_mem_i,
  input  logic [ID_WIDTH-1:0]           ib_is_branch_i,
  input  logic [ID_WIDTH-1:0]           ib_is_priv_i,
  output logic [ID_WIDTH-1:0]           ib_accept_o,
  output logic [ID_WIDTH-1:0]           dispatch_valid_o,
  output logic [ID_WIDTH-1:0][31:0]     dispatch_pc_o,
  output logic [ID_WIDTH-1:0][31:0]     dispatch_instr_o,
  input  logic                          dispatch_ready_i,
  input  logic                          backend_empty_i,
  input  logic                          flush_i,
  output logic [1:0]                    state_o,
  output logic [CNT_WIDTH-1:0]          perf_dispatch_cnt_o
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_PRIV_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;

  logic [1:0] state;
  logic       stage_open;
  logic       accept_ok;
  logic       pair_ok;
  logic       acc0;
  logic       acc1;

  // A branch in slot 1 does not block pairing: the older instruction is still
  // dispatched first, so only slot 0's branch class matters.
  logic unused_br1;
  assign unused_br1 = ib_is_branch_i[1];

  assign stage_open = (dispatch_valid_o == '0) || dispatch_ready_i;
  assign accept_ok  = !rst && (state == ST_RUN) && stage_open && !flush_i;

  // Slot 1 may only ride along when it cannot conflict with slot 0: no
  // control transfer ahead of it, no privileged op in either slot, and at
  // most one memory op per bundle.
  assign pair_ok = ib_valid_i[1] && !ib_is_branch_i[0] && !ib_is_priv_i[0] &&
                   !ib_is_priv_i[1] && !(ib_is_mem_i[0] && ib_is_mem_i[1]);

  assign acc0        = accept_ok && ib_valid_i[0];
  assign acc1        = acc0 && pair_ok;
  assign ib_accept_o = {acc1, acc0};
  assign state_o     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_RUN;
      dispatch_valid_o <= '0;
      dispatch_pc_o    <= '0;
      dispatch_instr_o <= '0;
    end else if (flush_i) begin
      state            <= ST_FLUSH;
      dispatch_valid_o <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (acc0 && ib_is_priv_i[0]) state <= ST_PRIV_DRAIN;
        end
        ST_PRIV_DRAIN: begin
          if ((dispatch_valid_o == '0) && backend_empty_i) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase

      if (acc0) begin
        dispatch_valid_o    <= {acc1, 1'b1};
        dispatch_pc_o[0]    <= ib_pc_i[0];
        dispatch_instr_o[0] <= ib_instr_i[0];
        if (acc1) begin
          dispatch_pc_o[1]    <= ib_pc_i[1];
          dispatch_instr_o[1] <= ib_instr_i[1];
        end
      end else if (stage_open) begin
        dispatch_valid_o <= '0;
      end
    end
  end

  // Counts what decode actually consumed; a flushed bundle is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dispatch_cnt_o <= '0;
    end else if (dispatch_ready_i && !flush_i) begin
      perf_dispatch_cnt_o <= perf_dispatch_cnt_o + CNT_WIDTH'(dispatch_valid_o[0])
                                                 + CNT_WIDTH'(dispatch_valid_o[1]);
    end
  end

endmodule

// File: tb/tb_id_dispatch_ctrl.sv
module tb_id_dispatch_ctrl;

  logic             clk;
  logic             rst;
  logic [1:0]       ib_valid_i;
  logic [1:0][31:0] ib_pc_i;
  logic [1:0][31:0] ib_instr_i;
  logic [1:0]       ib_is_mem_i, ib_is_branch_i, ib_is_priv_i;
  logic             dispatch_ready_i, backend_empty_i, flush_i;

  logic [1:0]       ib_accept_o, dispatch_valid_o, state_o;
  logic [1:0][31:0] dispatch_pc_o, dispatch_instr_o;
  logic [31:0]      perf_dispatch_cnt_o;

  logic [1:0]       acc4, vld4, st4;
  logic [1:0][31:0] pc4, instr4;
  logic [3:0]       cnt4;

  id_dispatch_ctrl dut (
    .clk(clk), .rst(rst),
    .ib_valid_i(ib_valid_i), .ib_pc_i(ib_pc_i), .ib_instr_i(ib_instr_i),
    .ib_is_mem_i(ib_is_mem_i), .ib_is_branch_i(ib_is_branch_i), .ib_is_priv_i(ib_is_priv_i),
    .ib_accept_o(ib_accept_o), .dispatch_valid_o(dispatch_valid_o),
    .dispatch_pc_o(dispatch_pc_o), .dispatch_instr_o(dispatch_instr_o),
    .dispatch_ready_i(dispatch_ready_i), .backend_empty_i(backend_empty_i),
    .flush_i(flush_i), .state_o(state_o), .perf_dispatch_cnt_o(perf_dispatch_cnt_o)
  );

  // Narrow-counter build driven by the same stimulus, to exercise counter wrap.
  id_dispatch_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .ib_valid_i(ib_valid_i), .ib_pc_i(ib_pc_i), .ib_instr_i(ib_instr_i),
    .ib_is_mem_i(ib_is_mem_i), .ib_is_branch_i(ib_is_branch_i), .ib_is_priv_i(ib_is_priv_i),
    .ib_accept_o(acc4), .dispatch_valid_o(vld4),
    .dispatch_pc_o(pc4), .dispatch_instr_o(instr4),
    .dispatch_ready_i(dispatch_ready_i), .backend_empty_i(backend_empty_i),
    .flush_i(flush_i), .state_o(st4), .perf_dispatch_cnt_o(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int err_cnt;
  int chk_cnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: state as a name, the pending bundle as a list of
  // instructions, and the counter as a plain running total.
  string       m_state;
  int          m_n;           // instructions currently held for decode
  logic [31:0] m_pc[2];
  logic [31:0] m_instr[2];
  longint      m_total;

  function automatic int issue_count();
    bit open;
    open = (m_n == 0) || dispatch_ready_i;
    if (rst || m_state != "RUN" || !open || flush_i || !ib_valid_i[0]) return 0;
    if (ib_valid_i[1] && !ib_is_branch_i[0] && !ib_is_priv_i[0] && !ib_is_priv_i[1] &&
        !(ib_is_mem_i[0] && ib_is_mem_i[1])) return 2;
    return 1;
  endfunction

  function automatic logic [1:0] mask_of(input int n);
    return (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
  endfunction

  task automatic model_reset();
    m_state = "RUN";
    m_n     = 0;
    m_total = 0;
  endtask

  function automatic logic [1:0] state_code(input string s);
    return (s == "RUN") ? 2'd0 : (s == "PRIV_DRAIN") ? 2'd1 : 2'd2;
  endfunction

  task automatic check_outputs();
    check("state", state_o, state_code(m_state));
    check("valid", dispatch_valid_o, mask_of(m_n));
    check("cnt32", perf_dispatch_cnt_o, m_total % 64'h1_0000_0000);
    check("cnt4", cnt4, m_total % 16);
    for (int i = 0; i < 2; i++) begin
      if (i < m_n) begin
        check($sformatf("pc%0d", i), dispatch_pc_o[i], m_pc[i]);
        check($sformatf("instr%0d", i), dispatch_instr_o[i], m_instr[i]);
      end
    end
  endtask

  // Inputs are stable from just after a rising edge; accept is sampled at
  // mid-cycle, the model advances on the edge, registered outputs at edge+1.
  task automatic step();
    int n;
    int old_n;
    bit open;
    #4;
    n = issue_count();
    check("accept", ib_accept_o, mask_of(n));
    check("accept4", acc4, mask_of(n));
    @(posedge clk);
    old_n = m_n;
    open  = (m_n == 0) || dispatch_ready_i;
    if (dispatch_ready_i && !flush_i) m_total += m_n;
    if (flush_i) begin
      m_state = "FLUSH";
      m_n     = 0;
    end else begin
      if (m_state == "RUN" && n > 0 && ib_is_priv_i[0]) m_state = "PRIV_DRAIN";
      else if (m_state == "PRIV_DRAIN" && old_n == 0 && backend_empty_i) m_state = "RUN";
      else if (m_state == "FLUSH") m_state = "RUN";
      if (n > 0) begin
        m_n = n;
        for (int i = 0; i < n; i++) begin
          m_pc[i]    = ib_pc_i[i];
          m_instr[i] = ib_instr_i[i];
        end
      end else if (open) begin
        m_n = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  logic [31:0] pc_base;

  task automatic drive(input logic [1:0] v, input logic [1:0] mem,
                       input logic [1:0] br, input logic [1:0] priv);
    ib_valid_i     = v;
    ib_is_mem_i    = mem;
    ib_is_branch_i = br;
    ib_is_priv_i   = priv;
    ib_pc_i[0]     = pc_base;
    ib_pc_i[1]     = pc_base + 32'd4;
    ib_instr_i[0]  = $urandom;
    ib_instr_i[1]  = $urandom;
    pc_base        = pc_base + 32'd8;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_state", state_o, 2'd0);
    check("rst_valid", dispatch_valid_o, 2'd0);
    check("rst_accept", ib_accept_o, 2'd0);
    check("rst_cnt", perf_dispatch_cnt_o, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    pc_base = 32'h1c00_0000;
    rst = 1'b1;
    flush_i = 1'b0;
    dispatch_ready_i = 1'b1;
    backend_empty_i = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 2'b00);
    model_reset();
    #2;
    check("rst_accept0", ib_accept_o, 2'b00);
    check("rst_valid0", dispatch_valid_o, 2'b00);
    check("rst_pc0", dispatch_pc_o[0], 32'd0);
    check("rst_instr1", dispatch_instr_o[1], 32'd0);
    check("rst_state0", state_o, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two ALU instructions at 0x1c000000/4.
    pc_base = 32'h1c00_0000;
    drive(2'b11, 2'b00, 2'b00, 2'b00);
    #4;
    check("alu_pair_acc", ib_accept_o, 2'b11);
    #1; #1;
    pc_base = 32'h1c00_0000;
    ib_pc_i[0] = 32'h1c00_0000; ib_pc_i[1] = 32'h1c00_0004;
    #0;
    // realign to edge+1 and run the pair through the model
    @(posedge clk); #1;
    model_reset();
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 2'b00);
    ib_pc_i[0] = 32'h1c00_0000; ib_pc_i[1] = 32'h1c00_0004;
    step();
    check("alu_pair_vld", dispatch_valid_o, 2'b11);
    check("alu_pair_pc1", dispatch_pc_o[1], 32'h1c00_0004);
    drive(2'b00, 2'b00, 2'b00, 2'b00);
    step();
    check("alu_pair_cnt", perf_dispatch_cnt_o, 32'd2);

    // Counter wrap on the 4-bit build: reach 15, then a pair -> 1.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(2'b11, 2'b00, 2'b00, 2'b00);
      step();
    end
    drive(2'b01, 2'b00, 2'b00, 2'b00);
    step();
    drive(2'b11, 2'b00, 2'b00, 2'b00);
    step();
    check("wrap_pre", cnt4, 4'd15);
    drive(2'b00, 2'b00, 2'b00, 2'b00);
    step();
    check("wrap_cnt4", cnt4, 4'd1);
    check("wrap_cnt32", perf_dispatch_cnt_o, 32'd17);

    // Both slots mem: one per cycle, old slot 1 moves to slot 0.
    drive(2'b11, 2'b11, 2'b00, 2'b00);
    step();
    check("mem_mem_vld", dispatch_valid_o, 2'b01);
    ib_pc_i[0] = ib_pc_i[1];
    ib_instr_i[0] = ib_instr_i[1];
    ib_pc_i[1] = ib_pc_i[1] + 32'd4;
    step();
    check("mem_shift_vld", dispatch_valid_o, 2'b01);

    // Branch in slot 0 blocks pairing.
    drive(2'b11, 2'b00, 2'b01, 2'b00);
    step();
    check("br_vld", dispatch_valid_o, 2'b01);

    // Privileged op drains the backend before anything else is accepted.
    drive(2'b11, 2'b00, 2'b00, 2'b01);
    backend_empty_i = 1'b0;
    step();
    check("priv_state", state_o, 2'd1);
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 2'b00, 2'b00, 2'b00);
      step();
    end
    backend_empty_i = 1'b1;
    step();
    check("priv_exit", state_o, 2'd0);

    // Backpressure hold, then flush.
    drive(2'b11, 2'b00, 2'b00, 2'b00);
    step();
    dispatch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b00, 2'b00, 2'b00);
      step();
    end
    check("hold_vld", dispatch_valid_o, 2'b11);
    dispatch_ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    check("flush_state", state_o, 2'd2);
    flush_i = 1'b0;
    step();
    check("flush_exit", state_o, 2'd0);

    // Reset in the middle of PRIV_DRAIN and of FLUSH.
    backend_empty_i = 1'b0;
    drive(2'b01, 2'b00, 2'b00, 2'b01);
    step();
    step();
    #2;
    do_reset();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #2;
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 2'($urandom_range(0, 2) == 0 ? 2'b00 : 2'($urandom)),
            {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)},
            {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)});
      dispatch_ready_i = ($urandom_range(0, 3) != 0);
      backend_empty_i  = $urandom_range(0, 1);
      flush_i          = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/id_dispatch_ctrl.md
ID_DISPATCH_CTRL -- requirements
Module: id_dispatch_ctrl

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 2, number of dispatch slots; only 2 is supported.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of the dispatch performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ib_valid_i  in  2  per-slot valid from instruction buffer head; slot 0 is oldest.
REQ-006 ib_pc_i / ib_instr_i  in  2x32 each  per-slot PC and instruction word.
REQ-007 ib_is_mem_i / ib_is_branch_i / ib_is_priv_i  in  2 each  per-slot pre-decode class bits.
REQ-008 ib_accept_o  out  2  combinational accept mask returned to the instruction buffer.
REQ-009 dispatch_valid_o  out  2  registered per-slot valid to decode.
REQ-010 dispatch_pc_o / dispatch_instr_o  out  2x32 each  registered payload to decode.
REQ-011 dispatch_ready_i  in  1  decode consumes the whole output bundle this cycle.
REQ-012 backend_empty_i  in  1  no instruction in flight past decode.
REQ-013 flush_i  in  1  backend flush (branch miss/exception).
REQ-014 state_o  out  2  current FSM state: 0 RUN, 1 PRIV_DRAIN, 2 FLUSH.
REQ-015 perf_dispatch_cnt_o  out  CNT_WIDTH  count of instructions handed to decode.

Function
REQ-016 Output stage SHALL be "open" when no dispatch_valid_o bit is set or dispatch_ready_i is 1.
REQ-017 ib_accept_o SHALL be 0 unless state is RUN, stage is open and flush_i is 0.
REQ-018 ib_accept_o[0] SHALL equal ib_valid_i[0] when accept is permitted by REQ-017.
REQ-019 ib_accept_o[1] SHALL be 1 only if ib_accept_o[0] and ib_valid_i[1], and not: slot 0 branch, slot 0 or slot 1 priv, or both slots mem.
REQ-020 ib_accept_o SHALL always be a prefix mask (2'b10 never produced).
REQ-021 On any accepted cycle, dispatch registers SHALL load accepted slots next edge; unaccepted slot valid cleared.
REQ-022 If stage open, no accept and no flush, dispatch_valid_o SHALL clear next edge; if stage not open, outputs SHALL hold.
REQ-023 Latency ib_accept_o to dispatch_valid_o SHALL be exactly 1 cycle.
REQ-024 RUN -> PRIV_DRAIN when ib_accept_o[0] is 1 and ib_is_priv_i[0] is 1.
REQ-025 PRIV_DRAIN -> RUN when dispatch_valid_o is 0 and backend_empty_i is 1 in the same cycle; no accepts while in PRIV_DRAIN.
REQ-026 flush_i SHALL have top priority: next edge clears dispatch_valid_o, enters FLUSH from any state, counter not incremented for that cycle's outputs.
REQ-027 FLUSH SHALL last exactly one cycle then go to RUN, unless flush_i is again 1 (stays FLUSH).
REQ-028 perf_dispatch_cnt_o SHALL add popcount(dispatch_valid_o) when dispatch_ready_i is 1 and flush_i is 0; wraps modulo 2^CNT_WIDTH.
REQ-029 Payload registers of invalid slots SHALL be don't-care; checks apply only to valid slots.

Reset
REQ-030 On rst assertion, asynchronously: state RUN, dispatch_valid_o 0, dispatch_pc_o/instr_o 0, perf_dispatch_cnt_o 0.
REQ-031 ib_accept_o SHALL be 0 while rst is asserted.
REQ-032 Reset mid-PRIV_DRAIN or mid-FLUSH SHALL return to RUN with no pending dispatch.

Verification
REQ-033 Two ALU instrs (pc 0x1c000000/0x1c000004) valid, ready=1 -> accept 2'b11, next cycle valid 2'b11, counter +2.
REQ-034 Slot0 mem, slot1 mem -> accept 2'b01; next cycle slot1 becomes slot0 -> accept 2'b01 again.
REQ-035 Slot0 branch, slot1 ALU -> accept 2'b01; dispatch_valid_o 2'b01.
REQ-036 Slot0 priv -> accept 2'b01, state 1; backend_empty_i held 0 for 5 cycles -> accept 0 throughout; backend_empty_i=1 -> state 0 next cycle.
REQ-037 dispatch_valid 2'b11, ready=0 for 3 cycles -> outputs hold, accept 0; flush_i pulse -> valid 0, state 2 one cycle, then 0, counter unchanged.
REQ-038 Counter preset near 2^CNT_WIDTH-1 (CNT_WIDTH=4 build), dispatch 2 -> counter wraps to 1.
